branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side partner of the pipeline hazard unit. Predicts taken/target for the fetch PC using a direct-mapped BTB with 2-bit saturating counters.
- Carries each prediction through shadow ID/EX/MEM registers that obey the hazard unit's flush/disable controls.
- At MEM it compares the prediction with the resolved outcome and drives `wrong` plus the restore PC that the hazard unit consumes.
- Trains the BTB on retirement and keeps prediction statistics.

Parameters:
- BTB_IDX_W, 4, index bits; BTB has 2**BTB_IDX_W entries indexed by PC[BTB_IDX_W+1:2].
- TAG_W, 30-BTB_IDX_W, tag width; tag = PC[31:BTB_IDX_W+2].

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- pc_if  input  32  current fetch PC, word aligned.
- predict_taken  output  1  combinational: valid BTB hit at pc_if with counter[1]=1.
- predict_target  output  32  BTB target when predict_taken=1, else 32'h0.
- pc_disable  input  1  hazard unit: IF holds.
- ifid_disable, idex_disable  input  1 each  hazard unit: stage holds.
- ifid_flush, idex_flush, exmem_flush  input  1 each  hazard unit: stage becomes bubble.
- exmem_disable  input  1  MEM entry holds (memory stall); tie 0 if unused.
- is_branch_mem  input  1  MEM instruction is BEQ/BNE.
- takebranch_mem  input  1  resolved branch outcome.
- branch_target_mem  input  32  resolved branch target.
- wrong  output  1  MEM prediction mismatch (combinational).
- pc_restore_mem  output  32  shadow MEM PC + 4 (fall-through for pcsrc 3'b100).
- branch_count, mispredict_count  output  32 each  statistics.

Behaviour:
- Reset (RST=1 at CLK edge): all BTB valid=0, counters=2'b01, tags/targets=0, shadow ID/EX/MEM valid=0, stats=0.
  - Outputs after reset: predict_taken=0, predict_target=0, wrong=0, pc_restore_mem=4.
  - RST overrides every other input, including a mispredict present in MEM.
- Lookup is combinational from pc_if. Hit requires valid and tag match.
- Shadow entry = {valid, pc, pred_taken, pred_target}.
- Shadow stage advance; flush has priority over disable at every stage:
  - ID: ifid_flush -> valid=0; else if ifid_disable -> hold; else <- {1, pc_if, predict_taken, predict_target}.
  - EX: idex_flush -> valid=0; else if idex_disable -> hold; else <- ID.
  - MEM: exmem_flush -> valid=0; else if exmem_disable -> hold; else <- EX.
  - pc_disable alone does not affect shadows; IF is unregistered.
- wrong = MEM.valid AND one of:
  - is_branch_mem AND pred_taken != takebranch_mem;
  - is_branch_mem AND takebranch_mem AND pred_target != branch_target_mem;
  - !is_branch_mem AND pred_taken (BTB alias).
- Training fires once per retirement: MEM.valid AND !exmem_disable. It writes the entry indexed by MEM.pc.
  - Branch, hit: counter saturating +1 if taken, -1 if not taken (range 00..11). Target overwritten when taken.
  - Branch, miss, taken: allocate with valid=1, tag, target, counter=2'b10.
  - Branch, miss, not taken: no write.
  - Non-branch with pred_taken: clear entry valid.
- Lookup and training on the same index in the same cycle: the lookup returns pre-update contents (no bypass).
- Statistics, both saturating at 32'hFFFFFFFF, updated only on retirement:
  - branch_count +1 per retired branch.
  - mispredict_count +1 per retirement with wrong=1.
- pc_restore_mem = MEM.pc + 4, wrapping modulo 2^32.

Test Plan:
1. Reset, pc_if=0x40 -> predict_taken=0, predict_target=0, wrong=0, both counts 0.
2. Branch at 0x40 flows unstalled to MEM with pred 0, takebranch_mem=1, target 0x100 -> wrong=1, branch_count=1, mispredict_count=1. Next cycle pc_if=0x40 -> predict_taken=1, predict_target=0x100.
3. Same branch predicted taken, resolved not taken -> wrong=1, pc_restore_mem=0x44, counter 10->01. Next lookup of 0x40 -> predict_taken=0.
4. Entry at 0x40 hit, MEM is_branch_mem=0 -> wrong=1, entry invalidated. Next lookup of 0x40 -> predict_taken=0.
5. ifid_disable=idex_disable=1 with exmem_flush=1 for 2 cycles -> ID/EX shadows unchanged, MEM bubble, wrong=0, counts unchanged. Release -> held instruction reaches MEM exactly once.
6. RST asserted while MEM holds a mispredict -> next cycle wrong=0, predict_taken=0 for 0x40, counts=0.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_predictor : direct-mapped BTB with 2-bit counters, shadow ID/EX/MEM
//                    prediction pipeline, MEM-stage mispredict check, stats.
// Revision 1.0
// ----------------------------------------------------------------------------
module branch_predictor #(
  parameter int BTB_IDX_W = 4,
  parameter int TAG_W     = 30 - BTB_IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_if,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        pc_disable,
  input  logic        ifid_disable,
  input  logic        idex_disable,
  input  logic        ifid_flush,
  input  logic        idex_flush,
  input  logic        exmem_flush,
  input  logic        exmem_disable,
  input  logic        is_branch_mem,
  input  logic        takebranch_mem,
  input  logic [31:0] branch_target_mem,
  output logic        wrong,
  output logic [31:0] pc_restore_mem,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int BTB_N = 1 << BTB_IDX_W;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } shadow_t;

  logic [BTB_N-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0] btb_tag_q [BTB_N];
  logic [TAG_W-1:0] btb_tag_d [BTB_N];
  logic [31:0]      btb_tgt_q [BTB_N];
  logic [31:0]      btb_tgt_d [BTB_N];
  logic [1:0]       btb_ctr_q [BTB_N];
  logic [1:0]       btb_ctr_d [BTB_N];

  shadow_t id_q, id_d, ex_q, ex_d, mem_q, mem_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  logic [BTB_IDX_W-1:0] if_idx, mem_idx;
  logic [TAG_W-1:0]     if_tag, mem_tag;
  logic                 if_hit, mem_hit, retire;

  // IF holds simply by the hazard unit not moving pc_if; low PC bits are always zero.
  logic unused_sigs;
  assign unused_sigs = ^{pc_disable, pc_if[1:0]};

  assign if_idx  = pc_if[BTB_IDX_W+1:2];
  assign if_tag  = pc_if[31:BTB_IDX_W+2];
  assign mem_idx = mem_q.pc[BTB_IDX_W+1:2];
  assign mem_tag = mem_q.pc[31:BTB_IDX_W+2];

  always_comb begin
    if_hit         = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    predict_taken  = if_hit && btb_ctr_q[if_idx][1];
    predict_target = predict_taken ? btb_tgt_q[if_idx] : 32'h0;
  end

  // Flush only drops the valid bit; the payload is left as it was.
  always_comb begin
    id_d = id_q;
    if (ifid_flush)         id_d.valid = 1'b0;
    else if (!ifid_disable) id_d = {1'b1, pc_if, predict_taken, predict_target};

    ex_d = ex_q;
    if (idex_flush)         ex_d.valid = 1'b0;
    else if (!idex_disable) ex_d = id_q;

    mem_d = mem_q;
    if (exmem_flush)         mem_d.valid = 1'b0;
    else if (!exmem_disable) mem_d = ex_q;
  end

  always_comb begin
    wrong = 1'b0;
    if (mem_q.valid) begin
      if (is_branch_mem)
        wrong = (mem_q.pred_taken != takebranch_mem) ||
                (takebranch_mem && (mem_q.pred_target != branch_target_mem));
      else
        wrong = mem_q.pred_taken;
    end
  end

  assign retire  = mem_q.valid && !exmem_disable;
  assign mem_hit = btb_valid_q[mem_idx] && (btb_tag_q[mem_idx] == mem_tag);

  always_comb begin
    btb_valid_d        = btb_valid_q;
    btb_tag_d          = btb_tag_q;
    btb_tgt_d          = btb_tgt_q;
    btb_ctr_d          = btb_ctr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (retire) begin
      if (is_branch_mem) begin
        if (mem_hit) begin
          if (takebranch_mem) begin
            if (btb_ctr_q[mem_idx] != 2'b11) btb_ctr_d[mem_idx] = btb_ctr_q[mem_idx] + 2'd1;
            btb_tgt_d[mem_idx] = branch_target_mem;
          end else if (btb_ctr_q[mem_idx] != 2'b00) begin
            btb_ctr_d[mem_idx] = btb_ctr_q[mem_idx] - 2'd1;
          end
        end else if (takebranch_mem) begin
          btb_valid_d[mem_idx] = 1'b1;
          btb_tag_d[mem_idx]   = mem_tag;
          btb_tgt_d[mem_idx]   = branch_target_mem;
          btb_ctr_d[mem_idx]   = 2'b10;
        end
        if (branch_count_q != 32'hFFFF_FFFF) branch_count_d = branch_count_q + 32'd1;
      end else if (mem_q.pred_taken) begin
        btb_valid_d[mem_idx] = 1'b0;
      end
      if (wrong && (mispredict_count_q != 32'hFFFF_FFFF))
        mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      btb_valid_q        <= '0;
      for (int i = 0; i < BTB_N; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_ctr_q[i] <= 2'b01;
      end
      id_q               <= '0;
      ex_q               <= '0;
      mem_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      btb_valid_q        <= btb_valid_d;
      btb_tag_q          <= btb_tag_d;
      btb_tgt_q          <= btb_tgt_d;
      btb_ctr_q          <= btb_ctr_d;
      id_q               <= id_d;
      ex_q               <= ex_d;
      mem_q              <= mem_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign pc_restore_mem   = mem_q.pc + 32'd4;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_predictor : directed vector table plus randomized run against a
//                       behavioural model of the predictor.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        CLK, RST;
  logic [31:0] pc_if;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        pc_disable, ifid_disable, idex_disable;
  logic        ifid_flush, idex_flush, exmem_flush, exmem_disable;
  logic        is_branch_mem, takebranch_mem;
  logic [31:0] branch_target_mem;
  logic        wrong;
  logic [31:0] pc_restore_mem, branch_count, mispredict_count;

  branch_predictor dut (
    .CLK(CLK), .RST(RST), .pc_if(pc_if),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .pc_disable(pc_disable), .ifid_disable(ifid_disable), .idex_disable(idex_disable),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .exmem_disable(exmem_disable), .is_branch_mem(is_branch_mem),
    .takebranch_mem(takebranch_mem), .branch_target_mem(branch_target_mem),
    .wrong(wrong), .pc_restore_mem(pc_restore_mem),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { bit v; logic [25:0] tag; logic [31:0] tgt; int ctr; } ent_t;
  typedef struct { bit v; logic [31:0] pc; bit pt; logic [31:0] tgt; } sh_t;

  ent_t        m_btb [16];
  sh_t         m_id, m_ex, m_mem;
  longint      m_bc, m_mc;

  function automatic int slot(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [25:0] tagof(logic [31:0] pc);
    return pc[31:6];
  endfunction

  function automatic bit m_pt(logic [31:0] pc);
    ent_t e = m_btb[slot(pc)];
    return e.v && (e.tag == tagof(pc)) && (e.ctr >= 2);
  endfunction

  function automatic logic [31:0] m_tgt(logic [31:0] pc);
    return m_pt(pc) ? m_btb[slot(pc)].tgt : 32'h0;
  endfunction

  function automatic bit m_wrong();
    if (!m_mem.v) return 1'b0;
    if (!is_branch_mem) return m_mem.pt;
    if (m_mem.pt != takebranch_mem) return 1'b1;
    return takebranch_mem && (m_mem.tgt != branch_target_mem);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_btb[i] = '{v: 0, tag: '0, tgt: '0, ctr: 1};
    m_id = '{v: 0, pc: '0, pt: 0, tgt: '0};
    m_ex = m_id;
    m_mem = m_id;
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_step();
    sh_t nid, nex, nmem;
    int  s;
    bit  hit;
    if (RST) begin
      model_reset();
      return;
    end
    nid  = m_id;
    nex  = m_ex;
    nmem = m_mem;
    if (ifid_flush) nid.v = 0;
    else if (!ifid_disable) nid = '{v: 1, pc: pc_if, pt: m_pt(pc_if), tgt: m_tgt(pc_if)};
    if (idex_flush) nex.v = 0;
    else if (!idex_disable) nex = m_id;
    if (exmem_flush) nmem.v = 0;
    else if (!exmem_disable) nmem = m_ex;
    if (m_mem.v && !exmem_disable) begin
      s   = slot(m_mem.pc);
      hit = m_btb[s].v && (m_btb[s].tag == tagof(m_mem.pc));
      if (m_wrong() && m_mc < 64'hFFFF_FFFF) m_mc++;
      if (is_branch_mem) begin
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (hit) begin
          m_btb[s].ctr = takebranch_mem ? ((m_btb[s].ctr + 1 > 3) ? 3 : m_btb[s].ctr + 1)
                                        : ((m_btb[s].ctr - 1 < 0) ? 0 : m_btb[s].ctr - 1);
          if (takebranch_mem) m_btb[s].tgt = branch_target_mem;
        end else if (takebranch_mem) begin
          m_btb[s] = '{v: 1, tag: tagof(m_mem.pc), tgt: branch_target_mem, ctr: 2};
        end
      end else if (m_mem.pt) begin
        m_btb[s].v = 0;
      end
    end
    m_id  = nid;
    m_ex  = nex;
    m_mem = nmem;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [5:0]  ctl;   // {ifid_dis, idex_dis, ifid_fl, idex_fl, exmem_fl, exmem_dis}
    logic        br, tk;
    logic [31:0] bt;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic        e_wrong;
    logic [31:0] e_rest, e_bc, e_mc;
  } vec_t;

  vec_t vq[$];

  task automatic add(logic r, logic [31:0] pc, logic [5:0] ctl, logic br, logic tk,
                     logic [31:0] bt, logic ept, logic [31:0] etgt, logic ew,
                     logic [31:0] erest, logic [31:0] ebc, logic [31:0] emc);
    vec_t v;
    v = '{rst: r, pc: pc, ctl: ctl, br: br, tk: tk, bt: bt, e_pt: ept, e_tgt: etgt,
          e_wrong: ew, e_rest: erest, e_bc: ebc, e_mc: emc};
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    RST = 0; pc_if = 32'h8; pc_disable = 0;
    {ifid_disable, idex_disable, ifid_flush, idex_flush, exmem_flush, exmem_disable} = '0;
    is_branch_mem = 0; takebranch_mem = 0; branch_target_mem = '0;
  endtask

  localparam logic [5:0] HOLD = 6'b110010;

  initial begin
    drive_idle();
    RST = 1;
    model_step();
    @(posedge CLK); #1;
    model_step();
    @(posedge CLK); #1;

    //     rst pc      ctl   br tk bt        pt tgt       wr rest      bc mc
    add(0, 32'h40, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h4,  0, 0); // reset state
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h4,  0, 0);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h4,  0, 0);
    add(0, 32'h08, 6'd0, 1, 1, 32'h100, 0, 32'h0,   1, 32'h44, 0, 0); // miss, taken
    add(0, 32'h40, 6'd0, 0, 0, 32'h0,   1, 32'h100, 0, 32'hC,  1, 1); // allocated
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  1, 1);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  1, 1);
    add(0, 32'h08, 6'd0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h44, 1, 1); // pred T, not taken
    add(0, 32'h40, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  2, 2); // counter 01
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  2, 2);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  2, 2);
    add(0, 32'h40, 6'd0, 1, 1, 32'h100, 0, 32'h0,   1, 32'h44, 2, 2); // same-slot, no bypass
    add(0, 32'h40, 6'd0, 0, 0, 32'h0,   1, 32'h100, 0, 32'hC,  3, 3);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  3, 3);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h44, 3, 3);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h44, 3, 3); // alias
    add(0, 32'h40, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  3, 4); // invalidated
    add(0, 32'h08, HOLD, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  3, 4); // hold + MEM flush
    add(0, 32'h08, HOLD, 1, 1, 32'h300, 0, 32'h0,   0, 32'hC,  3, 4);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  3, 4); // release
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  3, 4);
    add(0, 32'h08, 6'd0, 1, 1, 32'h100, 0, 32'h0,   1, 32'h44, 3, 4); // held branch in MEM
    add(0, 32'h40, 6'd0, 0, 0, 32'h0,   1, 32'h100, 0, 32'hC,  4, 5); // only once
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  4, 5);
    add(0, 32'h08, 6'd0, 0, 0, 32'h0,   0, 32'h0,   0, 32'hC,  4, 5);
    add(1, 32'h08, 6'd0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h44, 4, 5); // RST over mispredict
    add(0, 32'h40, 6'd0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h4,  0, 0);

    foreach (vq[i]) begin
      RST = vq[i].rst;
      pc_if = vq[i].pc;
      {ifid_disable, idex_disable, ifid_flush, idex_flush, exmem_flush, exmem_disable} = vq[i].ctl;
      is_branch_mem = vq[i].br;
      takebranch_mem = vq[i].tk;
      branch_target_mem = vq[i].bt;
      #2;
      chk("vec_pt",      i, {31'h0, predict_taken}, {31'h0, vq[i].e_pt});
      chk("vec_tgt",     i, predict_target, vq[i].e_tgt);
      chk("vec_wrong",   i, {31'h0, wrong}, {31'h0, vq[i].e_wrong});
      chk("vec_restore", i, pc_restore_mem, vq[i].e_rest);
      chk("vec_bcnt",    i, branch_count, vq[i].e_bc);
      chk("vec_mcnt",    i, mispredict_count, vq[i].e_mc);
      model_step();
      @(posedge CLK); #1;
    end

    // ---------------- randomized run against the model ----------------
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom_range(0, 299) == 0);
      pc_if = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 7) << 2);
      pc_disable    = ($urandom_range(0, 4) == 0);
      ifid_disable  = ($urandom_range(0, 4) == 0);
      idex_disable  = ($urandom_range(0, 4) == 0);
      exmem_disable = ($urandom_range(0, 5) == 0);
      ifid_flush    = ($urandom_range(0, 7) == 0);
      idex_flush    = ($urandom_range(0, 7) == 0);
      exmem_flush   = ($urandom_range(0, 7) == 0);
      is_branch_mem  = ($urandom_range(0, 2) != 0);
      takebranch_mem = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       branch_target_mem = 32'h100;
        1:       branch_target_mem = 32'h200;
        default: branch_target_mem = $urandom & 32'hFFFF_FFFC;
      endcase
      #2;
      chk("rnd_pt",      n, {31'h0, predict_taken}, {31'h0, m_pt(pc_if)});
      chk("rnd_tgt",     n, predict_target, m_tgt(pc_if));
      chk("rnd_wrong",   n, {31'h0, wrong}, {31'h0, m_wrong()});
      chk("rnd_restore", n, pc_restore_mem, m_mem.pc + 32'd4);
      chk("rnd_bcnt",    n, branch_count, m_bc[31:0]);
      chk("rnd_mcnt",    n, mispredict_count, m_mc[31:0]);
      model_step();
      @(posedge CLK); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
